// File: rtl/div_defs_pkg.sv
// div_defs_pkg: shared definitions for the sequential 16/8 divider.
//   state_t  - FSM encoding (IDLE, CHECK, RUN, DONE)
//   DW       - operand width of divisor, quotient and remainder
//   ITER     - number of restoring iterations (one quotient bit each)
//   ERR_QUO  - quotient reported on divide-by-zero or quotient overflow
package div_defs_pkg;

   localparam int DW   = 8;
   localparam int ITER = 8;

   localparam logic [DW-1:0] ERR_QUO = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (purely combinational).
//   p        - partial remainder with the next dividend bit appended (9 bits)
//   divisor  - divisor
//   qbit     - resolved quotient bit (1 when p >= divisor)
//   r_next   - partial remainder for the next iteration
module div_step
   import div_defs_pkg::*;
(
   input  logic [DW:0]   p,
   input  logic [DW-1:0] divisor,
   output logic          qbit,
   output logic [DW-1:0] r_next
);

   logic [DW-1:0] diff;
   logic          cout;

   // p[7:0] - divisor as p[7:0] + ~divisor + 1; cout=1 means no borrow.
   fa8b u_sub (
      .a    (p[DW-1:0]),
      .b    (~divisor),
      .cin  (1'b1),
      .sum  (diff),
      .cout (cout)
   );

   // When p[8] is set, p >= 256 > divisor. Because the incoming remainder
   // is below the divisor, p - divisor still fits 8 bits, so the wrapped
   // low-byte difference is the exact result.
   assign qbit   = p[DW] | cout;
   assign r_next = qbit ? diff : p[DW-1:0];

endmodule

// File: rtl/fa8b.sv
// fa8b: 8-bit adder with carry in/out, shared with the multiplier datapath.
//   a, b  - addends
//   cin   - carry in
//   sum   - 8-bit sum
//   cout  - carry out
module fa8b (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/div16by8_seq.sv
// div16by8_seq: sequential restoring divider, 16-bit dividend / 8-bit divisor.
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   start      - request, sampled only in IDLE
//   dividend   - 16-bit dividend, captured on the accepted start edge
//   divisor    - 8-bit divisor, captured on the accepted start edge
//   quo, rem   - 8-bit quotient / remainder, held until the next completion
//   busy       - high from the accept edge until DONE is left
//   done       - one-cycle completion pulse
//   dz, ovf    - divide-by-zero / quotient-overflow flags, valid with done
//   dbg_state  - current FSM state, for observation only
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// block is in IDLE (busy=0); operands are captured on that edge and start is
// ignored until busy falls. Completion is signalled by done=1 for exactly one
// cycle, with quo/rem/dz/ovf valid in that cycle; there is no back-pressure.
module div16by8_seq
   import div_defs_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2*DW-1:0] dividend,
   input  logic [DW-1:0]   divisor,
   output logic [DW-1:0]   quo,
   output logic [DW-1:0]   rem,
   output logic            busy,
   output logic            done,
   output logic            dz,
   output logic            ovf,
   output state_t          dbg_state
);

   state_t        state, state_n;
   logic [DW-1:0] r, r_n;        // partial remainder
   logic [DW-1:0] s, s_n;        // dividend low bits out, quotient bits in
   logic [DW-1:0] dvs, dvs_n;    // latched divisor
   logic [2:0]    cnt, cnt_n;    // iteration counter
   logic [DW-1:0] quo_n, rem_n;
   logic          busy_n, done_n, dz_n, ovf_n;

   logic          qbit;
   logic [DW-1:0] step_r;

   div_step u_step (
      .p       ({r, s[DW-1]}),
      .divisor (dvs),
      .qbit    (qbit),
      .r_next  (step_r)
   );

   always_comb begin
      state_n = state;
      r_n     = r;
      s_n     = s;
      dvs_n   = dvs;
      cnt_n   = cnt;
      quo_n   = quo;
      rem_n   = rem;
      busy_n  = busy;
      done_n  = 1'b0;
      dz_n    = dz;
      ovf_n   = ovf;
      case (state)
         IDLE: begin
            if (start) begin
               // High byte goes straight into R and low byte into S, so
               // CHECK only has to decide whether to enter RUN.
               r_n     = dividend[2*DW-1:DW];
               s_n     = dividend[DW-1:0];
               dvs_n   = divisor;
               cnt_n   = '0;
               dz_n    = 1'b0;
               ovf_n   = 1'b0;
               busy_n  = 1'b1;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (dvs == '0) begin
               dz_n    = 1'b1;
               quo_n   = ERR_QUO;
               rem_n   = s;
               done_n  = 1'b1;
               state_n = DONE;
            end else if (r >= dvs) begin
               // Quotient would need more than 8 bits.
               ovf_n   = 1'b1;
               quo_n   = ERR_QUO;
               rem_n   = s;
               done_n  = 1'b1;
               state_n = DONE;
            end else begin
               cnt_n   = '0;
               state_n = RUN;
            end
         end
         RUN: begin
            r_n   = step_r;
            s_n   = {s[DW-2:0], qbit};
            cnt_n = cnt + 3'd1;
            if (cnt == 3'(ITER - 1)) begin
               quo_n   = {s[DW-2:0], qbit};
               rem_n   = step_r;
               done_n  = 1'b1;
               state_n = DONE;
            end
         end
         DONE: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         r     <= '0;
         s     <= '0;
         dvs   <= '0;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dz    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         r     <= r_n;
         s     <= s_n;
         dvs   <= dvs_n;
         cnt   <= cnt_n;
         quo   <= quo_n;
         rem   <= rem_n;
         busy  <= busy_n;
         done  <= done_n;
         dz    <= dz_n;
         ovf   <= ovf_n;
      end
   end

   assign dbg_state = state;

endmodule
